// File: rtl/aes_key_expansion_seq_pkg.sv
// rtl/aes_key_expansion_seq_pkg.sv - shared AES key-schedule types, size encodings, S-box and GF(2^8) helpers
package aes_pkg;

    localparam int NR_MAX = 14;
    localparam int W_MAX  = 4 * (NR_MAX + 1);

    localparam logic [1:0] AES128 = 2'b00;
    localparam logic [1:0] AES192 = 2'b01;
    localparam logic [1:0] AES256 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } state_t;

    // Forward S-box, entry 0 in the MSBs.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [3:0] nk_of(input logic [1:0] size);
        case (size)
            AES128:  return 4'd4;
            AES192:  return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] size);
        case (size)
            AES128:  return 4'd10;
            AES192:  return 4'd12;
            default: return 4'd14;
        endcase
    endfunction

    function automatic logic [5:0] total_words(input logic [1:0] size);
        return {nr_of(size) + 4'd1, 2'b00};
    endfunction

    function automatic logic [255:0] key_mask(input logic [1:0] size);
        case (size)
            AES128:  return {{128{1'b1}}, 128'h0};
            AES192:  return {{192{1'b1}}, 64'h0};
            default: return {256{1'b1}};
        endcase
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expansion_seq_if.sv
// rtl/aes_key_expansion_seq_if.sv - request/response bundle between key requester and key schedule
interface aes_key_expansion_seq_if;
    import aes_pkg::*;

    logic                        start;
    logic [255:0]                key;
    logic [1:0]                  size;
    logic [128*(NR_MAX+1)-1:0]   key_out;
    logic                        busy;
    logic                        valid;

    modport master (output start, key, size, input key_out, busy, valid);
    modport slave  (input start, key, size, output key_out, busy, valid);

endinterface

// File: rtl/aes_key_expansion_seq_sub_word.sv
// rtl/aes_key_expansion_seq_sub_word.sv - SubWord: four parallel S-box lookups on one schedule word
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                       sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/aes_key_expansion_seq.sv
// rtl/aes_key_expansion_seq.sv - iterative AES-128/192/256 key schedule, one word per clock; KEY_EXP_CACHE_EN skips repeat expansions
module aes_key_expansion_seq
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    aes_key_expansion_seq_if.slave bus
);

    state_t      state;
    logic [31:0] w [W_MAX];
    logic [5:0]  idx;
    logic [5:0]  last_idx;
    logic [2:0]  j;
    logic [7:0]  rcon;
    logic [3:0]  nk_q;
    logic        busy_q;
    logic        valid_q;

    logic [31:0] prev_word;
    logic [31:0] back_word;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] t_word;
    logic        can_start;
    logic        hit;
    logic        go;

    always_comb begin
        prev_word = w[idx - 6'd1];
        back_word = w[idx - {2'b00, nk_q}];
        sub_in    = (j == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
        if (j == 3'd0)
            t_word = sub_out ^ {rcon, 24'h0};
        else if (nk_q == 4'd8 && j == 3'd4)
            t_word = sub_out;
        else
            t_word = prev_word;
    end

    aes_sub_word u_sub_word (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    assign can_start = bus.start && (state == ST_IDLE || state == ST_DONE);
    assign go        = can_start && !hit;

`ifdef KEY_EXP_CACHE_EN
    logic         cache_valid;
    logic [255:0] cache_key;
    logic [1:0]   cache_size;

    assign hit = cache_valid && state == ST_DONE && bus.size == cache_size
                 && ((bus.key & key_mask(bus.size)) == cache_key);

    // Cache is only trusted once the words it describes are fully written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_valid <= 1'b0;
            cache_key   <= '0;
            cache_size  <= '0;
        end else if (go) begin
            cache_valid <= 1'b0;
            cache_key   <= bus.key & key_mask(bus.size);
            cache_size  <= bus.size;
        end else if (state == ST_EXPAND && idx == last_idx) begin
            cache_valid <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < W_MAX; k++) w[k] <= '0;
            state    <= ST_IDLE;
            idx      <= '0;
            last_idx <= '0;
            j        <= '0;
            rcon     <= '0;
            nk_q     <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (go) begin
                        for (int k = 0; k < W_MAX; k++) w[k] <= '0;
                        for (int k = 0; k < 8; k++)
                            if (4'(k) < nk_of(bus.size)) w[k] <= bus.key[255-32*k -: 32];
                        idx      <= {2'b00, nk_of(bus.size)};
                        last_idx <= total_words(bus.size) - 6'd1;
                        nk_q     <= nk_of(bus.size);
                        j        <= 3'd0;
                        rcon     <= 8'h01;
                        state    <= ST_EXPAND;
                        busy_q   <= 1'b1;
                        valid_q  <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    w[idx] <= back_word ^ t_word;
                    idx    <= idx + 6'd1;
                    j      <= ({1'b0, j} == nk_q - 4'd1) ? 3'd0 : j + 3'd1;
                    if (j == 3'd0) rcon <= xtime(rcon);
                    if (idx == last_idx) begin
                        state   <= ST_DONE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Word w[4r+c] lands in round-key slot r, column c counted from the slot MSBs.
    for (genvar g = 0; g < W_MAX; g++) begin : g_map
        assign bus.key_out[128*(g/4) + 32*(3-(g%4)) +: 32] = w[g];
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;

endmodule
